// File: rtl/mips_pkg.sv
// Shared definitions for the execute-stage HI/LO unit: function codes,
// FSM state encoding, operand width and a conditional-negate helper.
package mips_pkg;

    localparam int XLEN = 32;

    // ALUFn function codes handled by the HI/LO unit
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Two's-complement negate when neg is set, pass-through otherwise
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// One iteration of the HI/LO arithmetic on a 2*XLEN accumulator.
// Multiply: acc = {partial product, remaining multiplier bits}; shift-add right.
// Divide:   acc = {partial remainder, dividend/quotient bits}; restoring step left.
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]   add_s;
    logic [XLEN:0]   part_s;
    logic            ge_s;
    logic [XLEN-1:0] diff_s;

    // Single shift-add or restoring-subtract step selected by operation type
    always_comb begin
        // Multiplicand is added when the current multiplier LSB is set; carry kept in bit XLEN
        if (acc_in[0]) begin
            add_s = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, opnd};
        end else begin
            add_s = {1'b0, acc_in[2*XLEN-1:XLEN]};
        end
        // Remainder shifted left with the next dividend bit; can be XLEN+1 bits wide
        part_s = acc_in[2*XLEN-1:XLEN-1];
        ge_s   = (part_s >= {1'b0, opnd});
        // True difference is below 2**XLEN whenever it is used, so modular XLEN math suffices
        diff_s = part_s[XLEN-1:0] - opnd;
        if (is_div) begin
            if (ge_s) begin
                acc_out = {diff_s, acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {acc_in[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {add_s, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage HI/LO unit: iterative MULT/MULTU/DIV/DIVU, single-cycle
// MTHI/MTLO, combinational MFHI/MFLO read port and a busy stall signal.
module mul_div_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      ALUFn,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] rd_data
);
    import mips_pkg::*;

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;
    logic              is_div_q, is_div_d;
    logic              is_signed_q, is_signed_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              dz_q, dz_d;

    logic              a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_abs_s, b_abs_s;
    logic [2*XLEN-1:0] acc_step_s;

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .is_div (is_div_q),
        .acc_in (acc_q),
        .opnd   (opnd_q),
        .acc_out(acc_step_s)
    );

    // FSM next state, operand preparation, iteration and HI/LO write-back
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        a_d         = a_q;
        b_d         = b_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        dz_d        = dz_q;

        a_neg_s = is_signed_q & a_q[XLEN-1];
        b_neg_s = is_signed_q & b_q[XLEN-1];
        a_abs_s = cond_neg(a_q, a_neg_s);
        b_abs_s = cond_neg(b_q, b_neg_s);

        if (flush) begin
            // Abort: drop the operation without touching HI/LO
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (ALUFn)
                            FN_MTHI: hi_d = a;
                            FN_MTLO: lo_d = a;
                            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                                a_d         = a;
                                b_d         = b;
                                is_div_d    = ALUFn[1];
                                is_signed_d = ~ALUFn[0];
                                state_d     = ST_PREP;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREP: begin
                    // Work on magnitudes; the dividend/multiplier sits in the low half
                    acc_d    = {{XLEN{1'b0}}, (is_div_q ? a_abs_s : b_abs_s)};
                    opnd_d   = is_div_q ? b_abs_s : a_abs_s;
                    neg_lo_d = a_neg_s ^ b_neg_s;
                    neg_hi_d = a_neg_s;
                    dz_d     = is_div_q & (b_q == {XLEN{1'b0}});
                    cnt_d    = {CW{1'b0}};
                    state_d  = ST_CALC;
                end
                ST_CALC: begin
                    acc_d = acc_step_s;
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_FIX: begin
                    if (dz_q) begin
                        // Divide by zero returns all-ones quotient and the raw dividend
                        hi_d = a_q;
                        lo_d = {XLEN{1'b1}};
                    end else if (is_div_q) begin
                        lo_d = cond_neg(acc_q[XLEN-1:0], neg_lo_q);
                        hi_d = cond_neg(acc_q[2*XLEN-1:XLEN], neg_hi_q);
                    end else if (neg_lo_q) begin
                        {hi_d, lo_d} = -acc_q;
                    end else begin
                        {hi_d, lo_d} = acc_q;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            hi_q        <= {XLEN{1'b0}};
            lo_q        <= {XLEN{1'b0}};
            done_q      <= 1'b0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            a_q         <= {XLEN{1'b0}};
            b_q         <= {XLEN{1'b0}};
            opnd_q      <= {XLEN{1'b0}};
            acc_q       <= {(2*XLEN){1'b0}};
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            a_q         <= a_d;
            b_q         <= b_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            dz_q        <= dz_d;
        end
    end

    // MFHI/MFLO read mux
    always_comb begin
        case (ALUFn)
            FN_MFHI: rd_data = hi_q;
            FN_MFLO: rd_data = lo_q;
            default: rd_data = {XLEN{1'b0}};
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected {hi,lo} pushed at issue,
// popped and compared by a monitor whenever done pulses.
module tb_mul_div_unit;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  ALUFn;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];

    mul_div_unit #(.XLEN(32), .ITER(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ALUFn  (ALUFn),
        .flush  (flush),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                check(name_q.pop_front(), {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic expect_result(input string name, input logic [31:0] eh, input logic [31:0] el);
        exp_q.push_back({eh, el});
        name_q.push_back(name);
    endtask

    task automatic issue(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1; ALUFn = fn; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_idle(output int busy_cycles, output int lat);
        busy_cycles = 0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) lat = cyc - start_cyc;
            if (busy === 1'b1) busy_cycles++;
            else break;
        end
    endtask

    task automatic run(input string name, input logic [5:0] fn, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
        int bc, lt;
        expect_result(name, eh, el);
        issue(fn, av, bv);
        wait_idle(bc, lt);
        check({name, "_busy_cycles"}, 64'(bc), 64'd34);
    endtask

    initial begin
        int bc, lt;
        rst_n = 1'b0; start = 1'b0; ALUFn = 6'h00; flush = 1'b0; a = 32'h0; b = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_lo", {32'h0, lo}, 64'h0);
        check("reset_busy_done", {62'h0, busy, done}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT -2 * 3 with latency and busy-duration checks
        expect_result("mult_neg2x3", 32'hFFFFFFFF, 32'hFFFFFFFA);
        issue(FN_MULT, 32'hFFFFFFFE, 32'h00000003);
        wait_idle(bc, lt);
        check("mult_latency", 64'(lt), 64'd34);
        check("mult_busy_cycles", 64'(bc), 64'd34);

        run("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run("div_neg7_2", FN_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu_by0", FN_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        run("div_by0_raw", FN_DIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run("divu_100_7", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Signed overflow, with an MTHI attempt mid-CALC that must be ignored
        expect_result("div_overflow", 32'h00000000, 32'h80000000);
        issue(FN_DIV, 32'h80000000, 32'hFFFFFFFF);
        repeat (10) @(negedge clk);
        start = 1'b1; ALUFn = FN_MTHI; a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        wait_idle(bc, lt);
        check("overflow_done_seen", 64'(lt > 0), 64'd1);

        // MTHI / MTLO and MFHI / MFLO reads
        issue(FN_MFLO, 32'h0, 32'h0);
        check("mflo_after_div", {32'h0, rd_data}, 64'h0000000080000000);
        issue(FN_MTHI, 32'h12345678, 32'h0);
        check("mthi_no_busy", {63'h0, busy}, 64'h0);
        ALUFn = FN_MFHI;
        #1;
        check("mfhi_read", {32'h0, rd_data}, 64'h0000000012345678);
        issue(FN_MTLO, 32'h0BADF00D, 32'h0);
        ALUFn = FN_MFLO;
        #1;
        check("mflo_read", {32'h0, rd_data}, 64'h000000000BADF00D);
        ALUFn = FN_MULT;
        #1;
        check("rd_data_other", {32'h0, rd_data}, 64'h0);

        // flush beats start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; ALUFn = FN_MULT; a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_over_start", {63'h0, busy}, 64'h0);

        // flush during CALC: no done, HI/LO untouched
        issue(FN_MULTU, 32'd3, 32'd4);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_low", {63'h0, busy}, 64'h0);
        repeat (40) @(negedge clk);
        check("flush_hilo_kept", {hi, lo}, 64'h12345678_0BADF00D);

        // Asynchronous reset mid-CALC, then a fresh multiply
        issue(FN_MULTU, 32'hFFFFFFFF, 32'd2);
        repeat (15) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_hilo", {hi, lo}, 64'h0);
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run("multu_5x6", FN_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog: never let the run hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
